// File: rtl/act_window_scanner_pkg.sv
// act_pkg: definitions shared by the activation-window scanner, the
// activation memory and the loader.
//   idx_t   : 16-bit row/column index used on every memory read port
//   state_t : scanner FSM states
//   out_dim : number of window positions along one axis
package act_pkg;

    typedef logic [15:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns 1 on an illegal geometry so that dependent widths stay sane.
    // The top flags that geometry separately as an elaboration error.
    function automatic int out_dim(input int dim, input int kdim, input int stride);
        if (stride <= 0 || kdim > dim) return 1;
        return (dim - kdim) / stride + 1;
    endfunction

endpackage

// File: rtl/act_window_scanner_win_counter.sv
// act_win_counter: row-major 2-D position counter over an OUT_DIM x OUT_DIM
// grid. x increments first; when x wraps, y increments. After the final
// position the counter wraps back to (0,0).
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : return to (0,0); has priority over advance
//   advance        : step to the next position
//   pos_y, pos_x   : current position
//   nxt_y, nxt_x   : position that an advance would produce
//   last           : current position is the final one
module act_win_counter
    import act_pkg::*;
#(
    parameter int OUT_DIM = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output idx_t pos_y,
    output idx_t pos_x,
    output idx_t nxt_y,
    output idx_t nxt_x,
    output logic last
);

    localparam idx_t MAX_POS = idx_t'(OUT_DIM - 1);

    idx_t r_y, r_x;
    logic w_last_x, w_last_y;

    assign w_last_x = (r_x == MAX_POS);
    assign w_last_y = (r_y == MAX_POS);

    always_comb begin
        nxt_x = w_last_x ? '0 : r_x + 16'd1;
        nxt_y = r_y;
        if (w_last_x) nxt_y = w_last_y ? '0 : r_y + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
            r_x <= '0;
        end else if (clear) begin
            r_y <= '0;
            r_x <= '0;
        end else if (advance) begin
            r_y <= nxt_y;
            r_x <= nxt_x;
        end
    end

    assign pos_y = r_y;
    assign pos_x = r_x;
    assign last  = w_last_x && w_last_y;

endmodule

// File: rtl/act_window_scanner.sv
// act_window_scanner: drives the activation memory read port and registers
// its combinational KERNEL_DIM x KERNEL_DIM window, producing one window per
// convolution output position in row-major order with a valid/ready slot.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start                      : begin a scan (accepted only when idle)
//   busy, done                 : scan in progress / one-cycle completion pulse
//   read_index_y, read_index_x : registered window origin to the memory
//   in_window                  : combinational window from the memory
//   out_window, out_y, out_x   : registered window and its output position
//   out_last, out_valid        : final-window marker, window valid
//   out_ready                  : downstream accepts the window
module act_window_scanner
    import act_pkg::*;
#(
    parameter int ENTRY_NUM  = 16,
    parameter int DIM        = 8,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 1,
    parameter int DATA_SIZE  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          read_index_y,
    output logic [15:0]          read_index_x,
    input  logic [DATA_SIZE-1:0] in_window  [ENTRY_NUM-1:0][KERNEL_DIM-1:0][KERNEL_DIM-1:0],
    output logic [DATA_SIZE-1:0] out_window [ENTRY_NUM-1:0][KERNEL_DIM-1:0][KERNEL_DIM-1:0],
    output logic [15:0]          out_y,
    output logic [15:0]          out_x,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int OUT_DIM = out_dim(DIM, KERNEL_DIM, STRIDE);

    if (KERNEL_DIM > DIM || STRIDE == 0) begin : g_bad_geometry
        $error("act_window_scanner: KERNEL_DIM must not exceed DIM and STRIDE must be nonzero");
    end

    state_t r_state, w_state_nxt;
    logic   w_clear, w_adv, w_cap, w_free, w_accept;
    idx_t   w_pos_y, w_pos_x, w_nxt_y, w_nxt_x;
    logic   w_last;

    idx_t   r_rd_y, r_rd_x;
    idx_t   r_out_y, r_out_x;
    logic   r_valid, r_last;
    logic [DATA_SIZE-1:0] r_window [ENTRY_NUM-1:0][KERNEL_DIM-1:0][KERNEL_DIM-1:0];

    // Slot is free when empty or being drained this cycle.
    assign w_free   = !r_valid || out_ready;
    assign w_accept = r_valid && out_ready;

    act_win_counter #(
        .OUT_DIM (OUT_DIM)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .advance (w_adv),
        .pos_y   (w_pos_y),
        .pos_x   (w_pos_x),
        .nxt_y   (w_nxt_y),
        .nxt_x   (w_nxt_x),
        .last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_adv       = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_clear     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_free) begin
                    w_cap = 1'b1;
                    w_adv = 1'b1;
                    if (w_last) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_accept && r_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read index tracks the counter one step ahead of the capture, so the
    // memory already presents the next window when the slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_y <= '0;
            r_rd_x <= '0;
        end else if (w_clear) begin
            r_rd_y <= '0;
            r_rd_x <= '0;
        end else if (w_adv) begin
            r_rd_y <= idx_t'(w_nxt_y * STRIDE);
            r_rd_x <= idx_t'(w_nxt_x * STRIDE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_out_y  <= '0;
            r_out_x  <= '0;
            r_window <= '{default: '0};
        end else if (w_cap) begin
            r_valid  <= 1'b1;
            r_last   <= w_last;
            r_out_y  <= w_pos_y;
            r_out_x  <= w_pos_x;
            r_window <= in_window;
        end else if (w_accept) begin
            r_valid  <= 1'b0;
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign read_index_y = r_rd_y;
    assign read_index_x = r_rd_x;
    assign out_valid    = r_valid;
    assign out_last     = r_last;
    assign out_y        = r_out_y;
    assign out_x        = r_out_x;
    assign out_window   = r_window;

endmodule

// File: doc/act_window_scanner.md
# act_window_scanner

Drives the read port of the parallel activation memory and turns its combinational KERNEL_DIM x KERNEL_DIM window output into a stream of registered windows, one per convolution output position, in row-major order. Sits directly downstream of the activation memory and upstream of the MAC/accumulate stage. Holds `busy` while scanning so the loader does not write the memory mid-scan.

## Interface
Parameters:
- `ENTRY_NUM`, 16: channels (memory entries) delivered per window.
- `DIM`, 8: activation map side length.
- `KERNEL_DIM`, 3: window side length.
- `STRIDE`, 1: step between window origins, in both x and y.
- `DATA_SIZE`, 64: element width (IEEE double bit pattern; never interpreted).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle pulse that begins a scan; ignored unless IDLE.
- `busy`, out, 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done`, out, 1: one-cycle pulse after the last window is accepted downstream.
- `read_index_y`, out, 16: window origin row presented to the memory.
- `read_index_x`, out, 16: window origin column presented to the memory.
- `in_window`, in, `[DATA_SIZE-1:0] [ENTRY_NUM-1:0][KERNEL_DIM-1:0][KERNEL_DIM-1:0]`: combinational window from memory.
- `out_window`, out, same shape as `in_window`: registered window.
- `out_y`, out, 16: output-map row of `out_window`.
- `out_x`, out, 16: output-map column of `out_window`.
- `out_last`, out, 1: marks the final window of a scan.
- `out_valid`, out, 1: window valid.
- `out_ready`, in, 1: downstream accepts.

## Operation
- `OUT_DIM = (DIM-KERNEL_DIM)/STRIDE + 1` (integer division), giving `OUT_DIM*OUT_DIM` windows per scan. Elaboration error if `KERNEL_DIM > DIM` or `STRIDE == 0`.
- FSM states:
  - IDLE: on `start`, go to SCAN with position (0,0).
  - SCAN: each cycle the slot is free (`!out_valid || out_ready`), capture `in_window` together with the position and last flag, then advance the position. x increments first; on wrap x returns to 0 and y increments. After capturing the final position, go to DRAIN.
  - DRAIN: when the final window is accepted (`out_valid && out_ready && out_last`), go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- `read_index_y/x = out_pos * STRIDE`. The index is registered and held constant while the slot is blocked.
- Handshake rules:
  - `out_valid` stays high and `out_window`/`out_y`/`out_x`/`out_last` stay stable until accepted.
  - No window is skipped or duplicated under any `out_ready` pattern.
- `start` outside IDLE is ignored. It is never queued.
- Reset values: `busy=0`, `done=0`, `out_valid=0`, `out_last=0`, `read_index_y/x=0`, `out_y/x=0`, `out_window` all zero. State is IDLE.
- Reset asserted mid-scan aborts immediately: no `done`, and pending `out_valid` drops.

## Timing
- `start` sampled high at edge 0 gives `busy=1` and index (0,0) after edge 0.
- The window is captured at edge 1, so `out_valid=1` after edge 1.
- With `out_ready` held high, throughput is 1 window per cycle. Window k becomes valid after edge k+1.
- `done` is high in the cycle after the edge that accepts the last window. `busy` falls with the end of `done`.
- `OUT_DIM=1`: one window with `out_last=1`, SCAN lasts one cycle.
- Full scan with continuous ready: `OUT_DIM*OUT_DIM + 2` cycles from `start` edge to `done`.

## Structure
- Shared package `act_pkg` holds:
  - the `OUT_DIM` function;
  - the FSM state enum (IDLE, SCAN, DRAIN, DONE);
  - the 16-bit index typedef shared with the memory and loader.
- One sub-module, `act_win_counter`: 2-D row-major position counter with `clear`/`advance` inputs and `pos_y`, `pos_x`, `last` outputs.
- FSM, capture register and index multiply live in the top.

## Test plan
- DIM=4, KERNEL_DIM=3, STRIDE=1, `out_ready=1`, memory preloaded with value y*16+x:
  - expect 4 windows in order (0,0),(0,1),(1,0),(1,1);
  - window (1,1) element [0][0] = 0x11;
  - `out_last` on the 4th window only;
  - `done` at cycle 6.
- DIM=7, K=3, STRIDE=2:
  - read indices step 0,2,4 in x and y;
  - 9 windows.
- Random `out_ready` (50%), DIM=8, K=3:
  - exactly 36 windows, no duplicates;
  - outputs stable while `out_valid && !out_ready`.
- `start` pulsed again mid-scan: ignored, window count unchanged, a single `done`.
- `rst_n` low after window 3 of 36:
  - all outputs go to reset values asynchronously, no `done`;
  - a new `start` rescans from (0,0).
- DIM=KERNEL_DIM=3: a single window, `out_last=1`, `done` at cycle 3.
